// File: rtl/team_06_audio_pkg.sv
// Shared types and constants for the team_06 PWM audio output stage.
// The LFSR helper is only referenced when TEAM_06_PWM_DITHER_EN is defined.
package team_06_audio_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } pwm_state_t;

  localparam logic [7:0] AUDIO_MID = 8'd128;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Right-shift Galois toggle mask for x^8 + x^6 + x^5 + x^4 + 1.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/team_06_pwm_timebase.sv
// PWM timebase: CLK_DIV prescaler feeding an 8-bit free-running PWM counter.
// boundary marks the last tick of a PWM period (pwm_cnt wraps 255 -> 0 on it).
module team_06_pwm_timebase #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tick,
  output logic [7:0] pwm_cnt,
  output logic       boundary
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_cnt_q;
  logic [7:0]      pwm_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      pwm_cnt_q <= 8'd0;
    end else if (tick) begin
      div_cnt_q <= '0;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end else begin
      div_cnt_q <= div_cnt_q + DivW'(1);
    end
  end

  assign tick     = (div_cnt_q == DivMax);
  assign pwm_cnt  = pwm_cnt_q;
  assign boundary = tick && (pwm_cnt_q == 8'hFF);

endmodule

// File: rtl/team_06_pwm_audio_out.sv
// PWM audio output: latches samples at period boundaries, ramps duty on enable changes.
// Optional dither on loaded samples when TEAM_06_PWM_DITHER_EN is defined.
module team_06_pwm_audio_out
  import team_06_audio_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned RAMP_STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] audio_in,
  input  logic       enable,
  output logic       pwm_out,
  output logic       sample_req,
  output logic       active
);

  logic       tick;
  logic       boundary;
  logic [7:0] pwm_cnt;

  team_06_pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .pwm_cnt  (pwm_cnt),
    .boundary (boundary)
  );

  pwm_state_t state_q;
  logic [7:0] duty_q;
  logic       sample_req_q;
  logic       upd;

  // boundary already implies tick; both are named to keep the timebase contract visible.
  assign upd = boundary && tick;

  logic [8:0] ramp_up_sum;
  logic [7:0] duty_up;
  logic [7:0] duty_dn;
  logic [7:0] run_duty;

  always_comb begin
    ramp_up_sum = {1'b0, duty_q} + 9'(RAMP_STEP);
    duty_up     = (ramp_up_sum >= {1'b0, AUDIO_MID}) ? AUDIO_MID : ramp_up_sum[7:0];
    duty_dn     = ({1'b0, duty_q} > 9'(RAMP_STEP)) ? (duty_q - 8'(RAMP_STEP)) : 8'd0;
  end

`ifdef TEAM_06_PWM_DITHER_EN
  logic [7:0] lfsr_q;
  logic [8:0] dith_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (upd) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  always_comb begin
    dith_sum = {1'b0, audio_in} + {8'd0, lfsr_q[0]};
    run_duty = dith_sum[8] ? 8'hFF : dith_sum[7:0];
  end
`else
  assign run_duty = audio_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= OFF;
      duty_q       <= 8'd0;
      sample_req_q <= 1'b0;
    end else begin
      sample_req_q <= 1'b0;
      if (upd) begin
        unique case (state_q)
          OFF: begin
            if (enable) begin
              state_q <= RAMP_UP;
              duty_q  <= duty_up;
            end else begin
              duty_q  <= 8'd0;
            end
          end
          RAMP_UP: begin
            if (!enable) begin
              state_q <= RAMP_DOWN;
            end else begin
              duty_q <= duty_up;
              if (duty_up == AUDIO_MID) state_q <= RUN;
            end
          end
          RUN: begin
            if (enable) begin
              duty_q       <= run_duty;
              sample_req_q <= 1'b1;
            end else begin
              state_q <= RAMP_DOWN;
              duty_q  <= AUDIO_MID;
            end
          end
          RAMP_DOWN: begin
            if (enable) begin
              state_q <= RAMP_UP;
            end else begin
              duty_q <= duty_dn;
              if (duty_dn == 8'd0) state_q <= OFF;
            end
          end
          default: state_q <= OFF;
        endcase
      end
    end
  end

  assign pwm_out    = (state_q != OFF) && (pwm_cnt < duty_q);
  assign sample_req = sample_req_q;
  assign active     = (state_q != OFF);

endmodule

// File: tb/tb_team_06_pwm_audio_out.sv
// Self-checking bench for team_06_pwm_audio_out (CLK_DIV=2, RAMP_STEP=32).
// Honours TEAM_06_PWM_DITHER_EN when the same macro is given to the bench build.
module tb_team_06_pwm_audio_out;

  localparam int CLK_DIV   = 2;
  localparam int RAMP_STEP = 32;
  localparam int PERIOD    = 256 * CLK_DIV;
`ifdef TEAM_06_PWM_DITHER_EN
  localparam int DITH = 1;
`else
  localparam int DITH = 0;
`endif

  localparam int M_OFF = 0, M_UP = 1, M_RUN = 2, M_DOWN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] audio_in = 8'd128;
  logic       enable = 1'b0;
  logic       pwm_out;
  logic       sample_req;
  logic       active;

  int n_tests = 0;
  int n_fail  = 0;

  team_06_pwm_audio_out #(
    .CLK_DIV   (CLK_DIV),
    .RAMP_STEP (RAMP_STEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .audio_in   (audio_in),
    .enable     (enable),
    .pwm_out    (pwm_out),
    .sample_req (sample_req),
    .active     (active)
  );

  always #5 clk = ~clk;

  // Behavioural model: period phase from a cycle count, rules applied at each period end.
  int         m_cyc   = 0;
  int         m_state = M_OFF;
  int         m_duty  = 0;
  bit         m_req   = 1'b0;
  bit         m_valid = 1'b0;
  logic [7:0] m_lfsr  = 8'hA5;
  int         m_next;

  always @(posedge clk) begin
    if (rst) begin
      m_cyc = 0; m_state = M_OFF; m_duty = 0; m_req = 1'b0;
      m_lfsr = 8'hA5; m_valid = 1'b1;
    end else begin
      m_req = 1'b0;
      if ((m_cyc % PERIOD) == PERIOD - 1) begin
        case (m_state)
          M_OFF: if (enable) begin
            m_state = M_UP;
            m_duty  = (RAMP_STEP > 128) ? 128 : RAMP_STEP;
          end
          M_UP: if (!enable) m_state = M_DOWN;
                else begin
                  m_next = m_duty + RAMP_STEP;
                  m_duty = (m_next > 128) ? 128 : m_next;
                  if (m_duty == 128) m_state = M_RUN;
                end
          M_RUN: if (enable) begin
                   m_next = int'(audio_in) + ((DITH != 0) ? int'(m_lfsr[0]) : 0);
                   m_duty = (m_next > 255) ? 255 : m_next;
                   m_req  = 1'b1;
                 end else begin
                   m_state = M_DOWN;
                   m_duty  = 128;
                 end
          default: if (enable) m_state = M_UP;
                   else begin
                     m_next = m_duty - RAMP_STEP;
                     m_duty = (m_next < 0) ? 0 : m_next;
                     if (m_duty == 0) m_state = M_OFF;
                   end
        endcase
        // x^8+x^6+x^5+x^4+1 as a right-shifting Galois register
        m_lfsr = m_lfsr[0] ? ({1'b0, m_lfsr[7:1]} ^ 8'hB8) : {1'b0, m_lfsr[7:1]};
      end
      m_cyc = m_cyc + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      automatic bit e_pwm = (m_state != M_OFF) && (((m_cyc % PERIOD) / CLK_DIV) < m_duty);
      automatic bit e_act = (m_state != M_OFF);
      n_tests = n_tests + 3;
      if (pwm_out !== e_pwm) begin
        n_fail = n_fail + 1;
        $display("FAIL model pwm_out cyc=%0d: got %b, expected %b", m_cyc, pwm_out, e_pwm);
      end
      if (sample_req !== m_req) begin
        n_fail = n_fail + 1;
        $display("FAIL model sample_req cyc=%0d: got %b, expected %b", m_cyc, sample_req, m_req);
      end
      if (active !== e_act) begin
        n_fail = n_fail + 1;
        $display("FAIL model active cyc=%0d: got %b, expected %b", m_cyc, active, e_act);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests = n_tests + 1;
    if (got != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_tests = n_tests + 1;
    if (got < lo || got > hi) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  function automatic int run_hi(input int a);
    return CLK_DIV * (((a + DITH) > 255) ? 255 : (a + DITH));
  endfunction

  task automatic wait_start();
    int guard = 0;
    while ((m_cyc % PERIOD) != 0 && guard < 2 * PERIOD) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2 * PERIOD) begin
      n_tests = n_tests + 1;
      n_fail  = n_fail + 1;
      $display("FAIL period sync: got no period start, expected one within %0d", 2 * PERIOD);
    end
  endtask

  // Count high cycles and request pulses over one whole period; optionally change inputs mid-way.
  task automatic measure(input string name, input int lo, input int hi, input int exp_req,
                         input bit set_mid, input logic [7:0] mid_audio, input bit mid_en);
    int highs = 0;
    int reqs  = 0;
    wait_start();
    for (int i = 0; i < PERIOD; i++) begin
      highs += int'(pwm_out);
      reqs  += int'(sample_req);
      if (set_mid && i == PERIOD / 2) begin
        audio_in = mid_audio;
        enable   = mid_en;
      end
      @(negedge clk);
    end
    check_range({name, " high cycles"}, highs, lo, hi);
    check({name, " sample_req pulses"}, reqs, exp_req);
  endtask

  task automatic start_playing();
    wait_start();
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int highs, reqs, acts;
    repeat (3) @(negedge clk);
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset sample_req", int'(sample_req), 0);
    check("reset active", int'(active), 0);
    rst = 1'b0;

    // Idle with enable low
    highs = 0; reqs = 0; acts = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      highs += int'(pwm_out);
      reqs  += int'(sample_req);
      acts  += int'(active);
    end
    check("idle pwm high cycles", highs, 0);
    check("idle sample_req pulses", reqs, 0);
    check("idle active cycles", acts, 0);

    // Ramp up: duty 32, 64, 96, 128 -> 2 clk cycles per tick
    start_playing();
    measure("ramp up 32", 64, 64, 0, 1'b0, 8'd0, 1'b1);
    measure("ramp up 64", 128, 128, 0, 1'b0, 8'd0, 1'b1);
    measure("ramp up 96", 192, 192, 0, 1'b1, 8'd200, 1'b1);
    measure("run entry 128", 256, 256, 0, 1'b0, 8'd0, 1'b1);
    measure("run audio 200", 400, run_hi(200), 1, 1'b1, 8'd0, 1'b1);
    measure("run audio 0", 0, run_hi(0), 1, 1'b1, 8'd255, 1'b1);
    measure("run audio 255", 510, run_hi(255), 1, 1'b1, 8'd255, 1'b0);

    // Ramp down with re-enable while duty is 64
    measure("ramp down 128", 256, 256, 0, 1'b0, 8'd0, 1'b0);
    check("ramp down active", int'(active), 1);
    measure("ramp down 96", 192, 192, 0, 1'b0, 8'd0, 1'b0);
    measure("ramp down 64", 128, 128, 0, 1'b1, 8'd255, 1'b1);
    measure("re-enable hold 64", 128, 128, 0, 1'b0, 8'd0, 1'b1);
    measure("re-ramp 96", 192, 192, 0, 1'b0, 8'd0, 1'b1);
    measure("re-run entry 128", 256, 256, 0, 1'b0, 8'd0, 1'b1);
    measure("re-run audio 255", 510, run_hi(255), 1, 1'b1, 8'd255, 1'b0);

    // Full ramp to OFF
    measure("final down 128", 256, 256, 0, 1'b0, 8'd0, 1'b0);
    measure("final down 96", 192, 192, 0, 1'b0, 8'd0, 1'b0);
    measure("final down 64", 128, 128, 0, 1'b0, 8'd0, 1'b0);
    measure("final down 32", 64, 64, 0, 1'b0, 8'd0, 1'b0);
    measure("off after ramp", 0, 0, 0, 1'b0, 8'd0, 1'b0);
    check("off active", int'(active), 0);

    // Reset in the middle of a RUN period while pwm_out is high
    start_playing();
    measure("second ramp 32", 64, 64, 0, 1'b0, 8'd0, 1'b1);
    measure("second ramp 64", 128, 128, 0, 1'b0, 8'd0, 1'b1);
    measure("second ramp 96", 192, 192, 0, 1'b1, 8'd200, 1'b1);
    measure("second run 128", 256, 256, 0, 1'b0, 8'd0, 1'b1);
    wait_start();
    repeat (20) @(negedge clk);
    check("mid-run pwm_out before reset", int'(pwm_out), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid-run reset pwm_out", int'(pwm_out), 0);
    check("mid-run reset sample_req", int'(sample_req), 0);
    check("mid-run reset active", int'(active), 0);
    rst    = 1'b0;
    enable = 1'b0;
    repeat (50) @(negedge clk);
    check("post reset active", int'(active), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
